// File: rtl/i2s_tx.sv
// i2s_tx: fractional-divider Philips I2S transmitter, 32-slot stereo frames at clk32*NUM/(2*DEN*32).
// Latency: audio is sampled on the falling bck edge entering slot 1; its MSB is driven in that same cycle.
// Backpressure: none; audio inputs are free-running and sampled once per frame.
module i2s_tx #(
    parameter int NUM = 12,
    parameter int DEN = 125
) (
    input  logic        clk32,
    input  logic        por,
    input  logic [15:0] audio_l,
    input  logic [15:0] audio_r,
    input  logic        mute,
    output logic        i2s_bck,
    output logic        i2s_ws,
    output logic        i2s_din,
    output logic        sample_strobe
);
    localparam int AW = $clog2(DEN + NUM);

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } stereo_t;

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic [AW:0]   acc_sum;
    logic          tick;
    logic [4:0]    p;
    logic [4:0]    p_nxt;
    stereo_t       smp;
    stereo_t       smp_in;
    logic [3:0]    bit_idx;
    logic          din_nxt;

    always_comb begin
        acc_sum = {1'b0, acc} + (AW+1)'(NUM);
        tick    = (acc_sum >= (AW+1)'(DEN));
        acc_nxt = tick ? AW'(acc_sum - (AW+1)'(DEN)) : acc_sum[AW-1:0];
        p_nxt   = p + 5'd1;
        smp_in  = mute ? '0 : {audio_l, audio_r};
        // (16 - p) mod 16 selects the bit for both words, including R[0] at slot 0
        bit_idx = 4'd0 - p_nxt[3:0];
        if (p_nxt == 5'd1) begin
            din_nxt = smp_in.l[15];
        end else if (p_nxt >= 5'd2 && p_nxt <= 5'd16) begin
            din_nxt = smp.l[bit_idx];
        end else begin
            din_nxt = smp.r[bit_idx];
        end
    end

    always_ff @(posedge clk32) begin
        if (por) begin
            acc           <= '0;
            i2s_bck       <= 1'b0;
            p             <= 5'd0;
            i2s_ws        <= 1'b0;
            i2s_din       <= 1'b0;
            smp           <= '0;
            sample_strobe <= 1'b0;
        end else begin
            acc           <= acc_nxt;
            sample_strobe <= 1'b0;
            if (tick) begin
                i2s_bck <= ~i2s_bck;
                // falling edge: advance slot and present the next bit
                if (i2s_bck) begin
                    p       <= p_nxt;
                    i2s_ws  <= p_nxt[4];
                    i2s_din <= din_nxt;
                    if (p_nxt == 5'd1) begin
                        smp           <= smp_in;
                        sample_strobe <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
